// File: rtl/affine_tap_accumulator.sv
// affine_tap_accumulator
//   Final stage of the 6-tap, 1/16-pel affine interpolation path. It takes
//   the six tap products already chosen by the MCM filters and the centre
//   sample. It applies the fixed tap signs and sums the products in a 3-stage
//   pipeline. It then rounds, shifts and optionally clips the result, and
//   hands it downstream over a valid/ready handshake.
//
//   Optional feature macro: AFFINE_TAP_CLIP_EN
//     defined   : the rounded result is saturated to the SAMPLE_W signed range
//     undefined : the rounded result is truncated to OUT_W, with no saturation
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   block can accept a beat
//   frac       fractional position 0..15 (0 = integer position, centre bypass)
//   center     signed centre sample (tap 2)
//   p0..p5     unsigned-magnitude tap products, taps 0..5
//   out_valid  result valid
//   out_ready  downstream accepts result
//   y          signed filtered sample
module affine_tap_accumulator #(
  parameter int SAMPLE_W = 8,
  parameter int PROD_W   = 15,
  parameter int ACC_W    = 18,
  parameter int SHIFT    = 6,
  parameter int OUT_W    = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 frac,
  input  logic signed [SAMPLE_W-1:0] center,
  input  logic [PROD_W-1:0]          p0,
  input  logic [PROD_W-1:0]          p1,
  input  logic [PROD_W-1:0]          p2,
  input  logic [PROD_W-1:0]          p3,
  input  logic [PROD_W-1:0]          p4,
  input  logic [PROD_W-1:0]          p5,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_W-1:0]    y
);

  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1 << (SHIFT-1));

  logic stall;

  logic                    v1, v2, v3;
  logic signed [ACC_W-1:0] s1_a, s1_b, s1_c;
  logic signed [ACC_W-1:0] s2_s;
  logic signed [OUT_W-1:0] s3_y;

  logic signed [ACC_W-1:0] pe0, pe1, pe2, pe3, pe4, pe5;
  logic signed [ACC_W-1:0] center_sh;
  logic signed [ACC_W-1:0] r_full;
  logic signed [OUT_W-1:0] y_next;

  // One global stall freezes every stage, so bubbles are kept in place.
  assign stall     = v3 & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v3;
  assign y         = s3_y;

  // The products are magnitudes, so they are zero-extended into the
  // accumulator. Any sign comes only from the fixed tap signs below.
  assign pe0 = {{(ACC_W-PROD_W){1'b0}}, p0};
  assign pe1 = {{(ACC_W-PROD_W){1'b0}}, p1};
  assign pe2 = {{(ACC_W-PROD_W){1'b0}}, p2};
  assign pe3 = {{(ACC_W-PROD_W){1'b0}}, p3};
  assign pe4 = {{(ACC_W-PROD_W){1'b0}}, p4};
  assign pe5 = {{(ACC_W-PROD_W){1'b0}}, p5};

  assign center_sh = {{(ACC_W-SAMPLE_W){center[SAMPLE_W-1]}}, center} <<< SHIFT;

  // Stage 1: partial sums. A bypass beat places the pre-shifted centre in
  // 'a' and zeros 'b' and 'c', so stage 2 needs no separate mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_c <= '0;
    end else if (!stall) begin
      v1 <= in_valid;
      if (in_valid) begin
        if (frac == 4'd0) begin
          s1_a <= center_sh;
          s1_b <= '0;
          s1_c <= '0;
        end else begin
          s1_a <= pe0 - pe1;
          s1_b <= pe2 + pe3;
          s1_c <= pe5 - pe4;
        end
      end
    end
  end

  // Stage 2: full sum, which wraps at ACC_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      s2_s <= '0;
    end else if (!stall) begin
      v2   <= v1;
      s2_s <= s1_a + s1_b + s1_c;
    end
  end

  // Stage 3 combinational: round half up, which also takes negative ties
  // toward +inf, then shift arithmetically.
  assign r_full = (s2_s + RND) >>> SHIFT;

`ifdef AFFINE_TAP_CLIP_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (SAMPLE_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = -ACC_W'(1 << (SAMPLE_W-1));

  logic signed [ACC_W-1:0] r_sat;

  always_comb begin
    r_sat = r_full;
    if (r_full > SAT_HI) begin
      r_sat = SAT_HI;
    end else if (r_full < SAT_LO) begin
      r_sat = SAT_LO;
    end
  end

  // The saturated value fits in SAMPLE_W bits, so truncating it to OUT_W
  // keeps its sign.
  assign y_next = r_sat[OUT_W-1:0];
`else
  assign y_next = r_full[OUT_W-1:0];
`endif

  // Stage 3: output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3   <= 1'b0;
      s3_y <= '0;
    end else if (!stall) begin
      v3   <= v2;
      s3_y <= y_next;
    end
  end

endmodule

// File: tb/tb_affine_tap_accumulator.sv
module tb_affine_tap_accumulator;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        frac;
  logic signed [7:0] center;
  logic [14:0]       p0, p1, p2, p3, p4, p5;
  logic              out_valid;
  logic              out_ready;
  logic signed [11:0] y;

  affine_tap_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .frac      (frac),
    .center    (center),
    .p0        (p0),
    .p1        (p1),
    .p2        (p2),
    .p3        (p3),
    .p4        (p4),
    .p5        (p5),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  typedef struct {
    int exp;
    int acc;
    bit lat;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_out = 0;
  int s0    = 0;
  bit stall_en = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want run to finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // Reference: signed sum of the taps, wrapped to 18 bits, then rounded
  // half up and shifted by 6.
  function automatic int model(input int f, input int c, input int q0, input int q1,
                               input int q2, input int q3, input int q4, input int q5);
    logic signed [17:0] s;
    logic signed [17:0] r;
    if (f == 0) s = 18'(c * 64);
    else        s = 18'(q0 - q1 + q2 + q3 - q4 + q5);
    r = (s + 18'sd32) >>> 6;
`ifdef AFFINE_TAP_CLIP_EN
    if (r > 18'sd127)  r = 18'sd127;
    if (r < -18'sd128) r = -18'sd128;
`endif
    return int'($signed(r[11:0]));
  endfunction

  // Runs at posedge + 1. Holds the beat until the negedge after in_ready
  // goes high, then records the expected result.
  task automatic send(input int f, input int c, input int q0, input int q1, input int q2,
                      input int q3, input int q4, input int q5, input bit lat);
    exp_t e;
    int guard;
    in_valid = 1'b1;
    frac     = 4'(f);
    center   = 8'(c);
    p0 = 15'(q0); p1 = 15'(q1); p2 = 15'(q2);
    p3 = 15'(q3); p4 = 15'(q4); p5 = 15'(q5);
    guard = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 100) begin
        chk_val("in_ready_timeout", 0, 1);
        break;
      end
    end
    e.exp = model(f, c, q0, q1, q2, q3, q4, q5);
    e.acc = cyc;
    e.lat = lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    chk_val("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    if (stall_en) out_ready = !((cyc >= s0 + 2) && (cyc <= s0 + 5));
  end

  // Output monitor: pop and compare on every transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid && !out_ready) chk_val("in_ready_stalled", int'(in_ready), 0);
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        chk_val("unexpected_out", int'($signed(y)), -9999);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk_val("y", int'($signed(y)), e.exp);
        if (e.lat) chk_val("latency", cyc - e.acc, 3);
      end
    end
  end

  initial begin
    int base;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    frac = '0; center = '0;
    p0 = '0; p1 = '0; p2 = '0; p3 = '0; p4 = '0; p5 = '0;
    #12;
    chk_val("rst_out_valid", int'(out_valid), 0);
    chk_val("rst_y", int'($signed(y)), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_val("rst_in_ready", int'(in_ready), 1);

    // Half-pel beat, whose tap sum is 128.
    send(8, 0, 4, 18, 78, 78, 18, 4, 1'b1);
    drain();

    // Integer-position bypass: the products must be ignored.
    send(0, -57, 1000, 1000, 1000, 1000, 1000, 1000, 1'b1);
    drain();

    // Rounding edges, sent back to back.
    send(1, 0, 0, 32, 0, 0, 0, 0, 1'b1);
    send(1, 0, 0, 33, 0, 0, 0, 0, 1'b1);
    send(1, 0, 0, 0, 95, 0, 0, 0, 1'b1);
    send(1, 0, 0, 0, 96, 0, 0, 0, 1'b1);
    drain();

    // Range edges; whether they clip depends on the build option.
    send(0, 127, 0, 0, 0, 0, 0, 0, 1'b1);
    send(5, 0, 0, 0, 12800, 0, 0, 0, 1'b1);
    send(5, 0, 0, 9600, 0, 0, 0, 0, 1'b1);
    drain();

    // Six beats in a stream, with out_ready low in cycles 2..5.
    base = n_out;
    s0 = cyc;
    stall_en = 1'b1;
    for (int k = 1; k <= 6; k++) send(3, 0, k, 0, 64 * k + 10 * k, 0, 0, 0, 1'b0);
    drain();
    stall_en = 1'b0;
    out_ready = 1'b1;
    chk_val("stream_count", n_out - base, 6);

    // Reset while three beats are in flight.
    send(2, 0, 0, 0, 640, 0, 0, 0, 1'b0);
    send(2, 0, 0, 0, 1280, 0, 0, 0, 1'b0);
    send(2, 0, 0, 0, 1920, 0, 0, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_val("midrst_out_valid", int'(out_valid), 0);
    chk_val("midrst_y", int'($signed(y)), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = n_out;
    send(7, 0, 0, 0, 320, 0, 0, 0, 1'b1);
    drain();
    chk_val("post_rst_count", n_out - base, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
